aes_ahb_master: RTL and testbench
=================================

# aes_ahb_master

AHB-Lite initiator that drives one complete AES job into the AES slave wrapper (`theWrapperFile`) and reads the result back. It issues the following transfer groups in order: mode select, 128-bit key burst, 64-byte plaintext/ciphertext burst, fixed processing wait, then a 64-byte readback burst. It sits between the system-side job interface and the slave's AHB port, and replaces the hand-driven master sequences used at top level.

## Interface
- PROC_WAIT, 40: idle cycles between the end of the block-write group and the start of the readback group.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- start  in  1  job request; sampled only in IDLE.
- decrypt  in  1  0 = encrypt, 1 = decrypt; captured with start.
- key_in  in  128  AES key; captured with start.
- data_in  in  512  four 128-bit blocks; [511:384] is block 1; captured with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at job end.
- err  out  1  set when a job aborts on HRESP error; cleared by the next accepted start.
- data_out  out  512  readback words; [511:480] is the word read from 0x80.
- HSELx, HWRITE  out  1  slave select, write strobe.
- HADDR, HWDATA  out  32  address, write data.
- HTRANS  out  2  IDLE=0, NONSEQ=2, SEQ=3.
- HBURST  out  3  SINGLE=0, INCR=1.
- HSIZE  out  3  constant 3'd2.
- HPROT  out  4  constant 0.
- HRDATA  in  32  read data.
- HREADY  in  1  transfer-complete / wait-state signal.
- HRESP  in  2  2'b01 = ERROR; all other values = OKAY.

## Operation
- FSM states: IDLE, MODE, KEY, BLK, WAIT, RD, DONE.
- Beat counter and data-phase counter are separate. Address phase N overlaps data phase N-1 (AHB pipelining).
- All bus outputs are registered.
- IDLE: start=1 latches decrypt, key_in and data_in, clears err, and enters MODE.
- MODE: one SINGLE NONSEQ write to 0x08 if decrypt, else 0x04. HWDATA=0 in its data phase.
- KEY: INCR write, 4 beats.
  - Addresses: 0x10 NONSEQ, then 0x14, 0x18, 0x1C SEQ.
  - Data phases carry key[127:96], [95:64], [63:32], [31:0].
- BLK: INCR write, 16 beats at 0x40..0x7C (NONSEQ then SEQ). Data words run from data_in[511:480] down to data_in[31:0].
- WAIT: PROC_WAIT cycles with HTRANS=IDLE and HSELx=0.
- RD: INCR read, 16 beats at 0x80..0xBC, HWRITE=0. The data phase of beat k loads HRDATA into data_out[511-32k -: 32].
- DONE: pulses done for one cycle, then returns to IDLE.
- Group boundary rules:
  - The final data phase of each group runs with HTRANS=IDLE, HSELx=0, HBURST=0, HADDR=0.
  - HWDATA returns to 0 the cycle after that phase.
  - The next group's NONSEQ starts in the following cycle.
- HREADY=0 at an edge: HADDR, HTRANS, HWDATA and the counters hold, and no HRDATA is captured. The WAIT counter still decrements.
- HRESP=2'b01 sampled during any transfer group:
  - The next cycle drives HTRANS=IDLE and HSELx=0.
  - err=1, and the FSM enters DONE.
  - data_out keeps only the words already captured.
- start while busy is ignored.
- HRESET=1 at an edge: every output returns to its reset value on that edge, even mid-burst.

## Timing
- Reset values:
  - HADDR, HWDATA, HTRANS, HBURST, HWRITE, HSELx, HPROT = 0.
  - HSIZE = 2.
  - busy, done, err = 0; data_out = 0.
- start sampled at edge E0 → MODE address phase is visible from E0 until E1.
- Zero wait states, cycle k = interval after edge Ek-1:
  - mode address: cycle 1; mode data: cycle 2.
  - key addresses: cycles 3–6; final key data: cycle 7.
  - block addresses: cycles 8–23; final block data: cycle 24.
  - WAIT: cycles 25..24+PROC_WAIT.
  - RD addresses: 16 cycles; final read data: one cycle later.
  - done high in cycle 42+PROC_WAIT; with default PROC_WAIT this is cycle 82.
- Each HREADY-low cycle extends the schedule by exactly one cycle.
- busy falls in the same cycle that done is high.

## Test plan
- Reset during KEY beat 2 (HRESET=1 for 2 cycles) → HTRANS=0, HSELx=0, busy=0 next cycle; a fresh start then runs from MODE.
- Encrypt job with key "ZXCVBNMASDFGHJKL" and data "1234567890123456"×4, slave model always ready:
  - HADDR sequence 0x04, 0x10..0x1C, 0x40..0x7C, 0x80..0xBC.
  - HWDATA 0x5A584356 in the data phase of 0x10.
  - done in cycle 82.
- Decrypt job → mode write address 0x08; data_out equals the slave model's 16 read words, 0x80 word in [511:480].
- HREADY held low 3 cycles at block beat 5 → HADDR stays 0x54 and HWDATA holds for those cycles; done arrives 3 cycles late (cycle 85).
- HRESP=2'b01 on read beat 3 → HTRANS=IDLE next cycle, err=1, done pulses, data_out[511:416] valid and remaining words 0.
- start pulsed while busy → no effect on the schedule; exactly one done pulse.

Source files
------------

// File: rtl/aes_ahb_if.sv
// AHB-Lite bus bundle between the AES job initiator and the AES slave.
// The master drives address/control/write data; the slave returns read data and status.
interface aes_ahb_if;
    logic        HSELx;
    logic        HWRITE;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HSELx, HWRITE, HADDR, HWDATA,
        output HTRANS, HBURST, HSIZE, HPROT,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSELx, HWRITE, HADDR, HWDATA,
        input  HTRANS, HBURST, HSIZE, HPROT,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/aes_ahb_master.sv
// AHB-Lite initiator running one AES job: mode, key, blocks,
// a fixed processing wait, then a 16-word readback into data_out.
module aes_ahb_master #(
    parameter int PROC_WAIT = 40
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         start,
    input  logic         decrypt,
    input  logic [127:0] key_in,
    input  logic [511:0] data_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [511:0] data_out,
    aes_ahb_if.master    bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MODE = 3'd1;
    localparam logic [2:0] ST_KEY  = 3'd2;
    localparam logic [2:0] ST_BLK  = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;
    localparam logic [2:0] ST_RD   = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    localparam logic [1:0] TR_IDLE = 2'd0;
    localparam logic [1:0] TR_NSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ  = 2'd3;
    localparam logic [2:0] BU_SNGL = 3'd0;
    localparam logic [2:0] BU_INCR = 3'd1;

    localparam int WW = (PROC_WAIT < 2) ? 1 : $clog2(PROC_WAIT + 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(PROC_WAIT);

    logic [2:0]    state;
    logic [3:0]    beat;
    logic [3:0]    dph;
    logic          aph;
    logic          dph_v;
    logic [WW-1:0] wcnt;
    logic [127:0]  key_r;
    logic [511:0]  data_r;

    logic [3:0]    last_beat;
    logic [31:0]   wr_word;
    logic          xfer_grp;
    logic          hresp_err;
    logic          rd_cap;

    assign bus.HSIZE = 3'd2;
    assign bus.HPROT = 4'd0;

    assign xfer_grp = (state == ST_MODE) || (state == ST_KEY)
                   || (state == ST_BLK) || (state == ST_RD);
    assign hresp_err = xfer_grp && (bus.HRESP == 2'b01);
    assign rd_cap = (state == ST_RD) && dph_v && bus.HREADY
                 && !hresp_err;

    // Word that goes out in the data phase following address beat `beat`.
    always_comb begin
        last_beat = 4'd15;
        wr_word   = '0;
        unique case (1'b1)
            state == ST_MODE: last_beat = 4'd0;
            state == ST_KEY: begin
                last_beat = 4'd3;
                wr_word   = key_r[{~beat[1:0], 5'b0} +: 32];
            end
            state == ST_BLK:
                wr_word = data_r[{~beat, 5'b0} +: 32];
            default: ;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            beat       <= '0;
            dph        <= '0;
            aph        <= 1'b0;
            dph_v      <= 1'b0;
            wcnt       <= '0;
            key_r      <= '0;
            data_r     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            data_out   <= '0;
            bus.HSELx  <= 1'b0;
            bus.HWRITE <= 1'b0;
            bus.HADDR  <= '0;
            bus.HWDATA <= '0;
            bus.HTRANS <= TR_IDLE;
            bus.HBURST <= BU_SNGL;
        end else begin
            done <= 1'b0;
            if (rd_cap)
                data_out[{~dph, 5'b0} +: 32] <= bus.HRDATA;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        key_r      <= key_in;
                        data_r     <= data_in;
                        err        <= 1'b0;
                        data_out   <= '0;
                        busy       <= 1'b1;
                        state      <= ST_MODE;
                        beat       <= '0;
                        aph        <= 1'b1;
                        dph_v      <= 1'b0;
                        bus.HSELx  <= 1'b1;
                        bus.HWRITE <= 1'b1;
                        bus.HTRANS <= TR_NSEQ;
                        bus.HBURST <= BU_SNGL;
                        bus.HADDR  <= decrypt ? 32'h08 : 32'h04;
                    end
                end

                ST_MODE, ST_KEY, ST_BLK, ST_RD: begin
                    if (hresp_err) begin
                        state      <= ST_DONE;
                        err        <= 1'b1;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        aph        <= 1'b0;
                        dph_v      <= 1'b0;
                        bus.HSELx  <= 1'b0;
                        bus.HWRITE <= 1'b0;
                        bus.HTRANS <= TR_IDLE;
                        bus.HBURST <= BU_SNGL;
                        bus.HADDR  <= '0;
                        bus.HWDATA <= '0;
                    end else if (bus.HREADY) begin
                        if (aph) begin
                            dph        <= beat;
                            dph_v      <= 1'b1;
                            bus.HWDATA <= wr_word;
                            if (beat == last_beat) begin
                                // Last data phase runs with the bus released.
                                aph        <= 1'b0;
                                bus.HSELx  <= 1'b0;
                                bus.HTRANS <= TR_IDLE;
                                bus.HBURST <= BU_SNGL;
                                bus.HADDR  <= '0;
                            end else begin
                                beat       <= beat + 4'd1;
                                bus.HADDR  <= bus.HADDR + 32'd4;
                                bus.HTRANS <= TR_SEQ;
                            end
                        end else begin
                            dph_v      <= 1'b0;
                            beat       <= '0;
                            bus.HWDATA <= '0;
                            case (state)
                                ST_MODE: begin
                                    state      <= ST_KEY;
                                    aph        <= 1'b1;
                                    bus.HSELx  <= 1'b1;
                                    bus.HWRITE <= 1'b1;
                                    bus.HTRANS <= TR_NSEQ;
                                    bus.HBURST <= BU_INCR;
                                    bus.HADDR  <= 32'h10;
                                end
                                ST_KEY: begin
                                    state      <= ST_BLK;
                                    aph        <= 1'b1;
                                    bus.HSELx  <= 1'b1;
                                    bus.HWRITE <= 1'b1;
                                    bus.HTRANS <= TR_NSEQ;
                                    bus.HBURST <= BU_INCR;
                                    bus.HADDR  <= 32'h40;
                                end
                                ST_BLK: begin
                                    state      <= ST_WAIT;
                                    wcnt       <= WAIT_INIT;
                                    bus.HWRITE <= 1'b0;
                                end
                                default: begin
                                    state      <= ST_DONE;
                                    done       <= 1'b1;
                                    busy       <= 1'b0;
                                    bus.HWRITE <= 1'b0;
                                end
                            endcase
                        end
                    end
                end

                ST_WAIT: begin
                    // Counts bus cycles, not accepted transfers.
                    wcnt <= wcnt - WW'(1);
                    if (wcnt <= WW'(1)) begin
                        state      <= ST_RD;
                        beat       <= '0;
                        aph        <= 1'b1;
                        bus.HSELx  <= 1'b1;
                        bus.HWRITE <= 1'b0;
                        bus.HTRANS <= TR_NSEQ;
                        bus.HBURST <= BU_INCR;
                        bus.HADDR  <= 32'h80;
                    end
                end

                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_ahb_master.sv
// Randomised scoreboard bench for aes_ahb_master with a responding AHB slave model.
// A job-level model queues every expected transfer and the job result.
module tb_aes_ahb_master;
    localparam int W = 40;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic        first;
        logic [2:0]  burst;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        int           cyc;
        logic         err;
        logic [511:0] dout;
    } job_t;

    logic         tb_HCLK = 1'b0;
    logic         tb_HRESET;
    logic         start;
    logic         decrypt;
    logic [127:0] key_in;
    logic [511:0] data_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [511:0] data_out;

    aes_ahb_if bus();

    aes_ahb_master #(.PROC_WAIT(W)) dut (
        .HCLK     (tb_HCLK),
        .HRESET   (tb_HRESET),
        .start    (start),
        .decrypt  (decrypt),
        .key_in   (key_in),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .data_out (data_out),
        .bus      (bus)
    );

    always #5 tb_HCLK = ~tb_HCLK;

    xfer_t       exp_q[$];
    job_t        job_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          ecnt = 0;
    int          job_e0 = 0;
    int          done_cnt = 0;
    int          njobs = 0;
    logic [31:0] rdmem[16];
    int          err_beat = 99;
    logic [31:0] stall_addr = 32'hFFFF_FFFF;
    int          stall_left = 0;
    bit          mon_en = 1'b1;

    always @(posedge tb_HCLK) ecnt <= ecnt + 1;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic push_x(input logic [31:0] a, input logic w,
                          input logic f, input logic [2:0] b,
                          input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.wr = w; x.first = f; x.burst = b; x.wdata = d;
        exp_q.push_back(x);
    endtask

    // Reference: the whole job as a transfer list plus its outcome.
    task automatic build_job(input bit dec, input logic [127:0] k,
                             input logic [511:0] d, input int eb,
                             input int ns);
        job_t j;
        int   nrd;
        push_x(dec ? 32'h08 : 32'h04, 1'b1, 1'b1, 3'd0, 32'h0);
        for (int i = 0; i < 4; i++)
            push_x(32'h10 + 4 * i, 1'b1, i == 0, 3'd1, k[127 - 32 * i -: 32]);
        for (int i = 0; i < 16; i++)
            push_x(32'h40 + 4 * i, 1'b1, i == 0, 3'd1, d[511 - 32 * i -: 32]);
        nrd = (eb < 16) ? ((eb + 2 > 16) ? 16 : eb + 2) : 16;
        for (int i = 0; i < nrd; i++)
            push_x(32'h80 + 4 * i, 1'b0, i == 0, 3'd1, 32'h0);
        j.dout = '0;
        for (int i = 0; i < 16; i++)
            if (i < eb) j.dout[511 - 32 * i -: 32] = rdmem[i];
        j.err = (eb < 16);
        j.cyc = (eb < 16) ? 27 + W + eb : 42 + W + ns;
        job_q.push_back(j);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r = {r[479:0], $urandom()};
        return r;
    endfunction

    // Slave: registered read data / response, HREADY stalls on a chosen address.
    initial begin : slave
        bit          acc;
        bit          wr;
        logic [31:0] a;
        bus.HREADY = 1'b1;
        bus.HRDATA = '0;
        bus.HRESP  = 2'b00;
        forever begin
            @(negedge tb_HCLK);
            acc = bus.HSELx && bus.HTRANS[1] && bus.HREADY;
            wr  = bus.HWRITE;
            a   = bus.HADDR;
            @(posedge tb_HCLK);
            #1;
            if (bus.HREADY) begin
                if (acc && !wr) begin
                    bus.HRDATA = rdmem[a[5:2]];
                    bus.HRESP  = (int'(a[5:2]) == err_beat) ? 2'b01 : 2'b00;
                end else begin
                    bus.HRDATA = '0;
                    bus.HRESP  = 2'b00;
                end
            end
            if (!tb_HRESET && bus.HSELx && bus.HTRANS[1]
                && bus.HADDR == stall_addr && stall_left > 0) begin
                bus.HREADY = 1'b0;
                stall_left--;
            end else begin
                bus.HREADY = 1'b1;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transfer or done.
    initial begin : monitor
        xfer_t       x;
        job_t        j;
        bit          pend;
        bit          pend_wr;
        logic [31:0] pend_d;
        int          k;
        pend = 1'b0;
        forever begin
            @(negedge tb_HCLK);
            if (!mon_en || tb_HRESET) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    if (bus.HREADY) begin
                        if (pend_wr) chk("wdata", bus.HWDATA, pend_d);
                        pend = 1'b0;
                    end else if (pend_wr) begin
                        chk("wdata_hold", bus.HWDATA, pend_d);
                    end
                end
                if (bus.HSELx && bus.HTRANS[1]) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_xfer: addr %08h, none required",
                                 bus.HADDR);
                    end else if (!bus.HREADY) begin
                        chk("addr_hold", bus.HADDR, exp_q[0].addr);
                    end else begin
                        x = exp_q.pop_front();
                        chk("haddr", bus.HADDR, x.addr);
                        chk("hwrite", bus.HWRITE, x.wr);
                        chk("htrans", bus.HTRANS, x.first ? 2'd2 : 2'd3);
                        chk("hburst", bus.HBURST, x.burst);
                        pend    = 1'b1;
                        pend_wr = x.wr;
                        pend_d  = x.wdata;
                    end
                end
                if (done) begin
                    if (job_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1, required 0");
                    end else begin
                        j = job_q.pop_front();
                        k = ecnt - job_e0 + 1;
                        done_cnt++;
                        chk("done_cycle", k, j.cyc);
                        chk("err_at_done", err, j.err);
                        chk("busy_at_done", busy, 1'b0);
                        chk("bus_idle_at_done", {bus.HSELx, bus.HTRANS}, 3'd0);
                        chk("data_out", data_out, j.dout);
                    end
                end
            end
        end
    end

    task automatic run_job(input bit dec, input logic [127:0] k,
                           input logic [511:0] d, input int eb,
                           input logic [31:0] sa, input int sn,
                           input int poke);
        int t;
        for (int i = 0; i < 16; i++) rdmem[i] = $urandom();
        err_beat   = eb;
        stall_addr = sa;
        stall_left = sn;
        @(negedge tb_HCLK);
        build_job(dec, k, d, eb, sn);
        decrypt = dec;
        key_in  = k;
        data_in = d;
        start   = 1'b1;
        @(negedge tb_HCLK);
        job_e0  = ecnt;
        start   = 1'b0;
        decrypt = ~dec;
        key_in  = ~k;
        data_in = ~d;
        njobs++;
        chk("busy_on_start", busy, 1'b1);
        chk("err_cleared", err, 1'b0);
        t = 0;
        while (job_q.size() != 0 && t < 400) begin
            @(negedge tb_HCLK);
            t++;
            start = (t == poke);
        end
        start = 1'b0;
        if (job_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL job_timeout: got no done in 400 cycles, required done");
            job_q.delete();
            exp_q.delete();
        end
        @(negedge tb_HCLK);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, required $finish");
        $fatal(1);
    end

    initial begin : stim
        logic [127:0] s16;
        logic [31:0]  sa;
        int           t;
        int           g;
        tb_HRESET = 1'b1;
        start     = 1'b0;
        decrypt   = 1'b0;
        key_in    = '0;
        data_in   = '0;
        repeat (3) @(negedge tb_HCLK);
        chk("rst_haddr", bus.HADDR, 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_htrans", bus.HTRANS, 2'd0);
        chk("rst_hburst", bus.HBURST, 3'd0);
        chk("rst_hwrite", bus.HWRITE, 1'b0);
        chk("rst_hsel", bus.HSELx, 1'b0);
        chk("rst_hprot", bus.HPROT, 4'd0);
        chk("rst_hsize", bus.HSIZE, 3'd2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_data_out", data_out, 512'h0);
        tb_HRESET = 1'b0;
        repeat (2) @(negedge tb_HCLK);

        s16 = "1234567890123456";
        run_job(1'b0, "ZXCVBNMASDFGHJKL", {s16, s16, s16, s16},
                99, 32'hFFFF_FFFF, 0, 0);
        run_job(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), 99, 32'hFFFF_FFFF, 0, 0);
        run_job(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), 99, 32'h54, 3, 0);
        run_job(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), 3, 32'hFFFF_FFFF, 0, 0);
        chk("err_sticky", err, 1'b1);

        // Reset in the middle of the key burst.
        mon_en   = 1'b0;
        err_beat = 99;
        @(negedge tb_HCLK);
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
        start  = 1'b1;
        @(negedge tb_HCLK);
        start = 1'b0;
        t = 0;
        while (!(bus.HADDR == 32'h18 && bus.HTRANS == 2'd3) && t < 20) begin
            @(negedge tb_HCLK);
            t++;
        end
        chk("key_beat2_addr", bus.HADDR, 32'h18);
        tb_HRESET = 1'b1;
        @(negedge tb_HCLK);
        chk("midrst_htrans", bus.HTRANS, 2'd0);
        chk("midrst_hsel", bus.HSELx, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_haddr", bus.HADDR, 32'h0);
        @(negedge tb_HCLK);
        tb_HRESET = 1'b0;
        mon_en    = 1'b1;
        @(negedge tb_HCLK);

        run_job(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), 99, 32'hFFFF_FFFF, 0, 0);
        run_job(1'b0, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), 99, 32'hFFFF_FFFF, 0, 40);
        repeat (100) @(negedge tb_HCLK);
        chk("done_count", done_cnt, njobs);
        chk("busy_idle", busy, 1'b0);

        for (int r = 0; r < 3; r++) begin
            g = $urandom_range(0, 2);
            case (g)
                0:       sa = 32'h10 + 4 * $urandom_range(0, 3);
                1:       sa = 32'h40 + 4 * $urandom_range(0, 15);
                default: sa = 32'h80 + 4 * $urandom_range(0, 15);
            endcase
            run_job(1'($urandom_range(0, 1)),
                    {$urandom(), $urandom(), $urandom(), $urandom()},
                    rnd512(), 99, sa, $urandom_range(0, 3), 0);
        end
        run_job(1'b1, {$urandom(), $urandom(), $urandom(), $urandom()},
                rnd512(), $urandom_range(0, 15), 32'hFFFF_FFFF, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
